// File: rtl/bg_sched_pkg.sv
// Shared types and constants for the background-picture SDRAM scheduler.
package bg_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WR,
        ISSUE_RD,
        WAIT_LO,
        WAIT_HI
    } state_t;

    localparam int unsigned WAIT_LO_MAX = 2;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned BYTE_W      = 8;

    // Bits needed to index n entries (n >= 2).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/bg_word_fifo.sv
// Show-ahead word FIFO with synchronous flush; head is read straight from storage.
module bg_word_fifo
    import bg_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = store[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    // Flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bg_sdram_sched.sv
// Shares the background SDRAM port between HPS byte downloads and display prefetch reads.
// Optional BG_UNDERFLOW_CNT_EN adds underflow_cnt, a saturating count of frames with an underflow.
module bg_sdram_sched
    import bg_sched_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 25,
    parameter int unsigned       FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    input  logic              ram_present,
    input  logic              frame_start,
    input  logic              pix_pop,
    output logic [15:0]       pix_data,
    output logic              pix_valid,
    output logic              bg_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [15:0]       mem_dout,
    input  logic              mem_ready,
    output logic              dl_overrun,
    output logic              underflow
`ifdef BG_UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int unsigned CNT_W  = clog2(FIFO_DEPTH) + 1;
    localparam int unsigned WCNT_W = clog2(WAIT_LO_MAX) + 1;

    state_t              state, state_nxt;
    logic                is_rd, is_rd_nxt;
    logic [WCNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic                mem_we_nxt, mem_rd_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [BYTE_W-1:0]   mem_din_nxt;
    logic                clr_held, rd_done;

    logic                held;
    logic [ADDR_W-1:0]   h_addr;
    logic [BYTE_W-1:0]   h_data;
    logic                stale;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                dl_active_q, dl_rise, dl_fall, wr_seen;
    logic                flush, rd_ok, push, uf_now;
    logic [CNT_W-1:0]    fifo_count;
    logic [WORD_W-1:0]   fifo_head;

    assign dl_rise = dl_active && !dl_active_q;
    assign dl_fall = !dl_active && dl_active_q;
    assign flush   = frame_start || dl_rise;
    assign push    = rd_done && !stale;
    assign uf_now  = pix_pop && (fifo_count == '0);
    // Only one command is ever outstanding, so nothing is in flight while IDLE.
    assign rd_ok   = bg_enable && !dl_active && (fifo_count < CNT_W'(FIFO_DEPTH));

    assign pix_valid = bg_enable && (fifo_count != '0);
    assign pix_data  = pix_valid ? fifo_head : '0;

    bg_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .push_data (mem_dout),
        .pop       (pix_pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            is_rd    <= 1'b0;
            wait_cnt <= '0;
            mem_we   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state    <= state_nxt;
            is_rd    <= is_rd_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_we   <= mem_we_nxt;
            mem_rd   <= mem_rd_nxt;
            mem_addr <= mem_addr_nxt;
            mem_din  <= mem_din_nxt;
        end
    end

    // Command sequencer: strobes are registered, so they appear in the first WAIT_LO cycle.
    always_comb begin
        state_nxt    = state;
        is_rd_nxt    = is_rd;
        wait_cnt_nxt = wait_cnt;
        mem_we_nxt   = 1'b0;
        mem_rd_nxt   = 1'b0;
        mem_addr_nxt = mem_addr;
        mem_din_nxt  = mem_din;
        clr_held     = 1'b0;
        rd_done      = 1'b0;
        case (state)
            IDLE: begin
                wait_cnt_nxt = '0;
                if (held) begin
                    state_nxt = ISSUE_WR;
                    is_rd_nxt = 1'b0;
                end else if (rd_ok) begin
                    state_nxt = ISSUE_RD;
                    is_rd_nxt = 1'b1;
                end
            end
            ISSUE_WR: begin
                if (mem_ready) begin
                    mem_we_nxt   = 1'b1;
                    mem_addr_nxt = h_addr;
                    mem_din_nxt  = h_data;
                    clr_held     = 1'b1;
                    state_nxt    = WAIT_LO;
                end
            end
            ISSUE_RD: begin
                if (mem_ready) begin
                    mem_rd_nxt   = 1'b1;
                    mem_addr_nxt = fetch_addr;
                    state_nxt    = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!mem_ready || (wait_cnt == WCNT_W'(WAIT_LO_MAX - 1))) begin
                    state_nxt = WAIT_HI;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                end
            end
            WAIT_HI: begin
                if (mem_ready) begin
                    rd_done   = is_rd;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write holding register; a new strobe always wins over the held byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            held       <= 1'b0;
            h_addr     <= '0;
            h_data     <= '0;
            dl_overrun <= 1'b0;
        end else begin
            if (clr_held) held <= 1'b0;
            if (dl_wr) begin
                held   <= 1'b1;
                h_addr <= dl_addr;
                h_data <= dl_data;
                if (held && !clr_held) dl_overrun <= 1'b1;
            end
        end
    end

    // A read caught by a flush still finishes on the bus but is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            stale      <= 1'b0;
            fetch_addr <= BASE_ADDR;
        end else begin
            if (state == IDLE)        stale <= 1'b0;
            else if (flush && is_rd)  stale <= 1'b1;
            if (flush)                fetch_addr <= BASE_ADDR;
            else if (push)            fetch_addr <= fetch_addr + ADDR_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_active_q <= 1'b0;
            wr_seen     <= 1'b0;
            bg_enable   <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            if (dl_rise)             wr_seen <= 1'b0;
            if (dl_wr && dl_active)  wr_seen <= 1'b1;
            if (dl_fall && ram_present && wr_seen) bg_enable <= 1'b1;
            if (uf_now)              underflow <= 1'b1;
        end
    end

`ifdef BG_UNDERFLOW_CNT_EN
    logic uf_frame;

    // An underflow on the frame_start cycle is charged to the frame that is ending.
    always_ff @(posedge clk) begin
        if (reset) begin
            uf_frame      <= 1'b0;
            underflow_cnt <= '0;
        end else if (frame_start) begin
            uf_frame <= 1'b0;
            if ((uf_frame || uf_now) && (underflow_cnt != 16'hFFFF))
                underflow_cnt <= underflow_cnt + 16'd1;
        end else if (uf_now) begin
            uf_frame <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bg_sdram_sched.sv
// Randomized bench for bg_sdram_sched with a latency-modelled SDRAM and address-derived read data.
module tb_bg_sdram_sched;

    localparam int unsigned ADDR_W     = 25;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [ADDR_W-1:0] BASE = '0;
    localparam int LAT_DEF = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              dl_active, dl_wr, ram_present, frame_start, pix_pop;
    logic [ADDR_W-1:0] dl_addr;
    logic [7:0]        dl_data;
    logic [15:0]       pix_data;
    logic              pix_valid, bg_enable, mem_we, mem_rd, dl_overrun, underflow;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [15:0]       mem_dout  = '0;
    logic              mem_ready = 1'b1;
`ifdef BG_UNDERFLOW_CNT_EN
    logic [15:0]       underflow_cnt;
`endif

    bg_sdram_sched #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dl_active   (dl_active),
        .dl_wr       (dl_wr),
        .dl_addr     (dl_addr),
        .dl_data     (dl_data),
        .ram_present (ram_present),
        .frame_start (frame_start),
        .pix_pop     (pix_pop),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .bg_enable   (bg_enable),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_rd      (mem_rd),
        .mem_dout    (mem_dout),
        .mem_ready   (mem_ready),
        .dl_overrun  (dl_overrun),
        .underflow   (underflow)
`ifdef BG_UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'd4660;
        return t[15:0];
    endfunction

    // SDRAM model: busy for a latency after each command, then ready with data for the address.
    int                busy = 0;
    bit                hold_ready = 1'b0;
    bit                rand_lat = 1'b0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [ADDR_W-1:0] rd_log[$];
    logic [ADDR_W-1:0] wr_a[$];
    logic [7:0]        wr_d[$];

    always @(negedge clk) begin
        if (reset) begin
            busy = 0;
        end else if (mem_rd || mem_we) begin
            check_eq("cmd_while_busy", 32'(busy), 32'd0);
            busy = rand_lat ? int'($urandom_range(4, 1)) : LAT_DEF;
            cur_addr = mem_addr;
            if (mem_rd) rd_log.push_back(mem_addr);
            if (mem_we) begin
                wr_a.push_back(mem_addr);
                wr_d.push_back(mem_din);
            end
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) mem_dout = word_of(cur_addr);
        end
        mem_ready = (busy == 0) && !hold_ready;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic dl_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        cyc();
        dl_wr   = 1'b0;
    endtask

    // Pixel side: pop only when a word is shown; words follow the fetch order from BASE.
    task automatic pop_stream(input int n, input int first, input string tag);
        int k = 0;
        int budget = 60 * n;
        while (k < n && budget > 0) begin
            cyc();
            budget--;
            if (pix_valid) begin
                check_eq(tag, 32'(pix_data), 32'(word_of(BASE + ADDR_W'(2 * (first + k)))));
                pix_pop = 1'b1;
                cyc();
                pix_pop = 1'b0;
                k++;
            end
        end
        if (k < n) check_eq({tag, "_timeout"}, 32'(k), 32'(n));
    endtask

    task automatic wait_rd(input int n);
        int k = 0;
        while (rd_log.size() <= n && k < 60) begin
            cyc();
            k++;
        end
        check_eq("rd_issued", 32'(rd_log.size() > n), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, base_w, k;
        logic [ADDR_W-1:0] ea[$];
        logic [7:0]        ed[$];
        logic [ADDR_W-1:0] ra;
        logic [7:0]        rd8;

        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        ram_present = 1'b0; frame_start = 1'b0; pix_pop = 1'b0;
        cycles(3);
        reset = 1'b0;
        cyc();
        check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst_pix_data", 32'(pix_data), 32'd0);
        check_eq("rst_bg_enable", 32'(bg_enable), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_overrun", 32'(dl_overrun), 32'd0);
        check_eq("rst_underflow", 32'(underflow), 32'd0);

        // Download two bytes
        ram_present = 1'b1;
        dl_active = 1'b1;
        cyc();
        dl_byte(25'h000, 8'h12);
        cycles(2);
        dl_byte(25'h001, 8'h34);
        cycles(15);
        check_eq("dl_wr_count", 32'(wr_a.size()), 32'd2);
        check_eq("dl_wr0_addr", 32'(wr_a[0]), 32'h000);
        check_eq("dl_wr0_data", 32'(wr_d[0]), 32'h12);
        check_eq("dl_wr1_addr", 32'(wr_a[1]), 32'h001);
        check_eq("dl_wr1_data", 32'(wr_d[1]), 32'h34);
        check_eq("dl_no_reads", 32'(rd_log.size()), 32'd0);
        check_eq("dl_bg_off", 32'(bg_enable), 32'd0);
        check_eq("dl_no_overrun", 32'(dl_overrun), 32'd0);
        dl_active = 1'b0;
        cycles(2);
        check_eq("bg_enable_set", 32'(bg_enable), 32'd1);

        // Prefetch fills exactly FIFO_DEPTH words without pops
        cycles(200);
        check_eq("pf_read_count", 32'(rd_log.size()), 32'(FIFO_DEPTH));
        for (int i = 0; i < int'(FIFO_DEPTH); i++)
            check_eq("pf_read_addr", 32'(rd_log[i]), 32'(BASE + ADDR_W'(2 * i)));
        check_eq("pf_valid", 32'(pix_valid), 32'd1);
        check_eq("pf_head", 32'(pix_data), 32'(word_of(BASE)));

        // Streaming under random memory latency
        rand_lat = 1'b1;
        pop_stream(64, 0, "stream");
        check_eq("stream_no_underflow", 32'(underflow), 32'd0);

        // frame_start while the read at 0x10 is in flight
        rand_lat = 1'b0;
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        cycles(200);
        n = rd_log.size();
        pop_stream(1, 0, "refill");
        wait_rd(n);
        check_eq("fs_inflight_addr", 32'(rd_log[n]), 32'h10);
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        check_eq("fs_flushed", 32'(pix_valid), 32'd0);
        k = 0;
        while (!pix_valid && k < 60) begin
            cyc();
            k++;
        end
        check_eq("fs_next_rd_seen", 32'(rd_log.size() > n + 1), 32'd1);
        check_eq("fs_next_rd_addr", 32'(rd_log[n+1]), 32'(BASE));
        check_eq("fs_first_word", 32'(pix_data), 32'(word_of(BASE)));
        pop_stream(8, 0, "after_flush");

        // Random download traffic, then an overrun against a stalled bus
        rand_lat = 1'b1;
        dl_active = 1'b1;
        cycles(20);
        check_eq("dl2_flushed", 32'(pix_valid), 32'd0);
        base_w = wr_a.size();
        for (int i = 0; i < 10; i++) begin
            ra  = ADDR_W'($urandom);
            rd8 = 8'($urandom);
            ea.push_back(ra);
            ed.push_back(rd8);
            dl_byte(ra, rd8);
            cycles(int'($urandom_range(20, 12)));
        end
        cycles(10);
        check_eq("dl2_wr_count", 32'(wr_a.size()), 32'(base_w + 10));
        for (int i = 0; i < 10; i++) begin
            check_eq("dl2_addr", 32'(wr_a[base_w + i]), 32'(ea[i]));
            check_eq("dl2_data", 32'(wr_d[base_w + i]), 32'(ed[i]));
        end
        check_eq("dl2_no_overrun", 32'(dl_overrun), 32'd0);
        hold_ready = 1'b1;
        cycles(2);
        dl_byte(25'h100, 8'hAA);
        dl_byte(25'h101, 8'hBB);
        cycles(3);
        check_eq("overrun_set", 32'(dl_overrun), 32'd1);
        hold_ready = 1'b0;
        cycles(20);
        check_eq("overrun_wr_count", 32'(wr_a.size()), 32'(base_w + 11));
        check_eq("overrun_addr", 32'(wr_a[wr_a.size() - 1]), 32'h101);
        check_eq("overrun_data", 32'(wr_d[wr_d.size() - 1]), 32'hBB);

        // Pop on an empty FIFO
        check_eq("uf_before", 32'(underflow), 32'd0);
        pix_pop = 1'b1; cyc(); pix_pop = 1'b0;
        check_eq("uf_set", 32'(underflow), 32'd1);
        check_eq("uf_pix_data", 32'(pix_data), 32'd0);
        check_eq("uf_pix_valid", 32'(pix_valid), 32'd0);
`ifdef BG_UNDERFLOW_CNT_EN
        check_eq("ufcnt_before", 32'(underflow_cnt), 32'd0);
`endif
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
`ifdef BG_UNDERFLOW_CNT_EN
        check_eq("ufcnt_after", 32'(underflow_cnt), 32'd1);
`endif
        dl_active = 1'b0;

        // Reset while a read waits for data
        rand_lat = 1'b0;
        cycles(5);
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        n = rd_log.size();
        wait_rd(n);
        cyc();
        reset = 1'b1;
        cyc();
        check_eq("rst2_mem_rd", 32'(mem_rd), 32'd0);
        check_eq("rst2_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst2_pix_valid", 32'(pix_valid), 32'd0);
        check_eq("rst2_bg_enable", 32'(bg_enable), 32'd0);
        check_eq("rst2_underflow", 32'(underflow), 32'd0);
        check_eq("rst2_overrun", 32'(dl_overrun), 32'd0);
        check_eq("rst2_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        n = rd_log.size();
        cycles(30);
        check_eq("rst2_no_reads", 32'(rd_log.size()), 32'(n));

        // Download without SDRAM fitted leaves the picture disabled
        ram_present = 1'b0;
        dl_active = 1'b1; cyc();
        dl_byte(25'h200, 8'h5A);
        cycles(10);
        dl_active = 1'b0;
        cycles(5);
        check_eq("noram_bg_off", 32'(bg_enable), 32'd0);
        check_eq("noram_wr_addr", 32'(wr_a[wr_a.size() - 1]), 32'h200);

        // Reload with SDRAM: fetch restarts at BASE
        ram_present = 1'b1;
        dl_active = 1'b1; cyc();
        dl_byte(25'h201, 8'hC3);
        cycles(10);
        n = rd_log.size();
        dl_active = 1'b0;
        cycles(40);
        check_eq("reload_bg_on", 32'(bg_enable), 32'd1);
        check_eq("reload_rd_seen", 32'(rd_log.size() > n), 32'd1);
        check_eq("reload_rd_addr", 32'(rd_log[n]), 32'(BASE));
        pop_stream(4, 0, "reload");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
